sha256_msg_sched: RTL

SHA-256 message schedule generator that sits directly downstream of `gen_padded`. It captures the 512-bit padded block when `gen_padded` asserts its ready strobe and expands the block into the 64 schedule words W0..W63. The words are streamed one per cycle, under a valid/ready handshake, to the compression round engine. When W63 has been accepted, it pulses a done strobe that the control glue routes back as `gen_padded`'s `finish_sig`.

---
 rtl/sha256_msg_sched.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched
// ----------------
// Captures a 512-bit padded block from gen_padded and streams the 64 SHA-256
// schedule words W0..W63, one per accepted transfer, to the round engine.
// A 16-word sliding window holds W[t]..W[t+15]. Each transfer emits win[0],
// shifts the window and appends the next schedule word.
//
// Ports
//   clock       : single clock; all state changes on the rising edge
//   reset       : asynchronous active-low reset, clears every register
//   pad_rdy     : padded block valid, sampled only in IDLE
//   pad_reg     : padded block, [511:480] = M0 ... [31:0] = M15
//   w_ready     : consumer accepts the current word
//   w_valid     : w_data / w_idx carry a valid schedule word
//   w_data      : schedule word Wt
//   w_idx       : round index t (0..63)
//   sched_busy  : high while a block is in flight (RUN and DONE)
//   sched_done  : one-cycle pulse after W63 has been accepted
//   dbg_state   : current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a word transfers on a rising edge where w_valid=1 and w_ready=1.
// While w_valid=1 and w_ready=0, w_data and w_idx hold. w_ready feeds only
// next-state logic, so no output depends combinationally on it.
module sha256_msg_sched #(
  parameter int NUM_ROUNDS = 64,
  parameter int WORD_WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      pad_rdy,
  input  logic [16*WORD_WIDTH-1:0]  pad_reg,
  input  logic                      w_ready,
  output logic                      w_valid,
  output logic [WORD_WIDTH-1:0]     w_data,
  output logic [5:0]                w_idx,
  output logic                      sched_busy,
  output logic                      sched_done,
  output logic [1:0]                dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  function automatic logic [WORD_WIDTH-1:0] rotr(input logic [WORD_WIDTH-1:0] x,
                                                 input int n);
    return (x >> n) | (x << (WORD_WIDTH - n));
  endfunction

  function automatic logic [WORD_WIDTH-1:0] sig0(input logic [WORD_WIDTH-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_WIDTH-1:0] sig1(input logic [WORD_WIDTH-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_e                state_q, state_d;
  logic [WORD_WIDTH-1:0] win_q [16];
  logic [WORD_WIDTH-1:0] win_d [16];
  logic [5:0]            t_q, t_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [WORD_WIDTH-1:0] next_word;

  // W[t+16] = s1(W[t+14]) + W[t+9] + s0(W[t+1]) + W[t], modulo 2^32.
  assign next_word = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      t_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int i = 0; i < 16; i++) begin
        win_q[i] <= win_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      win_d[i] = win_q[i];
    end

    unique case (state_q)
      S_IDLE: begin
        if (pad_rdy) begin
          for (int i = 0; i < 16; i++) begin
            win_d[i] = pad_reg[(15 - i) * WORD_WIDTH +: WORD_WIDTH];
          end
          t_d     = '0;
          state_d = S_RUN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_RUN: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        if (w_ready) begin
          for (int i = 0; i < 15; i++) begin
            win_d[i] = win_q[i + 1];
          end
          win_d[15] = next_word;
          t_d       = t_q + 6'd1;
          if (t_q == LAST_IDX) begin
            // Final word accepted: drop valid, raise the done pulse.
            state_d = S_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign w_valid    = valid_q;
  assign w_data     = win_q[0];
  assign w_idx      = t_q;
  assign sched_busy = busy_q;
  assign sched_done = done_q;
  assign dbg_state  = state_q;

endmodule
